// File: rtl/sigmoid_inv.sv
// Inverse sigmoid lookup. Given a sigmoid output y, the block returns the
// two's-complement input x of the first table entry that reaches y. It runs a
// fixed-length binary search over a non-decreasing table held in an
// asynchronous-read RAM. Valid/ready handshakes are used on both sides.

// Single-write, single-read RAM with a combinational read port. The table
// image named by filename_p is placed into mem_q by the device
// initialisation flow that owns the image file. This module only checks
// that filename_p names an image.
module ram_1r1w_async #(
  parameter int    width_p      = 8,
  parameter int    addr_width_p = 8,
  parameter int    els_p        = 256,
  parameter string filename_p   = "sigmoid.hex"
) (
  input  logic                    clk_i,
  input  logic                    wr_valid_i,
  input  logic [addr_width_p-1:0] wr_addr_i,
  input  logic [width_p-1:0]      wr_data_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic [width_p-1:0]      rd_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // A ROM without an image name is always a build mistake.
  if (filename_p == "") begin : g_no_image
    $error("ram_1r1w_async: filename_p must name a table image");
  end

  // Write port: one word per clock when enabled.
  always_ff @(posedge clk_i) begin
    if (wr_valid_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read is combinational, so data for rd_addr_i is valid in the same cycle.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

module sigmoid_inv #(
  parameter int    width_p    = 8,
  parameter string filename_p = "sigmoid.hex"
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] y_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] x_o
);

  localparam int depth_lp  = 1 << width_p;
  localparam int iter_w_lp = $clog2(width_p + 1);

  // Table address is x + 2^(width_p-1), so flipping the MSB converts between them.
  localparam logic [width_p-1:0]   sign_flip_lp = {1'b1, {(width_p-1){1'b0}}};
  localparam logic [width_p-1:0]   top_addr_lp  = {width_p{1'b1}};
  localparam logic [iter_w_lp-1:0] last_iter_lp = iter_w_lp'(width_p - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e               state_q,  state_d;
  logic [width_p-1:0]   y_q,      y_d;
  logic [width_p-1:0]   lo_q,     lo_d;
  logic [width_p-1:0]   hi_q,     hi_d;
  logic [width_p-1:0]   x_q,      x_d;
  logic                 valid_q,  valid_d;
  logic [iter_w_lp-1:0] iter_q,   iter_d;

  logic [width_p-1:0]   mid;
  logic [width_p-1:0]   mid_data;
  logic                 mid_ge;
  logic [width_p-1:0]   next_lo;
  logic [width_p-1:0]   next_hi;

  // Midpoint uses a sum one bit wider than the bounds so lo+hi cannot wrap.
  assign mid = width_p'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);

  ram_1r1w_async #(
    .width_p      (width_p),
    .addr_width_p (width_p),
    .els_p        (depth_lp),
    .filename_p   (filename_p)
  ) u_ram (
    .clk_i      (clk_i),
    .wr_valid_i (1'b0),
    .wr_addr_i  ({width_p{1'b0}}),
    .wr_data_i  ({width_p{1'b0}}),
    .rd_addr_i  (mid),
    .rd_data_o  (mid_data)
  );

  // Narrow the search window. If T[mid] already reaches y, the answer is at
  // or below mid. Otherwise the answer is strictly above mid.
  // With a power-of-two window, mid+1 never exceeds the top address.
  assign mid_ge  = (mid_data >= y_q);
  assign next_lo = mid_ge ? lo_q : (mid + width_p'(1));
  assign next_hi = mid_ge ? mid  : hi_q;

  // Next-state and datapath update for the IDLE -> SEARCH -> DONE sequence.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    x_d     = x_q;
    valid_d = valid_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          y_d     = y_i;
          lo_d    = {width_p{1'b0}};
          hi_d    = top_addr_lp;
          iter_d  = {iter_w_lp{1'b0}};
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        lo_d   = next_lo;
        hi_d   = next_hi;
        iter_d = iter_q + iter_w_lp'(1);
        // After width_p halvings the window has one address left. If no entry
        // reached y, lo has walked up to the top address.
        if (iter_q == last_iter_lp) begin
          x_d     = next_lo ^ sign_flip_lp;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // The result is held until the consumer takes it. valid_i is ignored here.
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers. An active-low synchronous reset drops any in-flight search.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      y_q     <= {width_p{1'b0}};
      lo_q    <= {width_p{1'b0}};
      hi_q    <= top_addr_lp;
      x_q     <= {width_p{1'b0}};
      valid_q <= 1'b0;
      iter_q  <= {iter_w_lp{1'b0}};
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      iter_q  <= iter_d;
    end
  end

  assign ready_o = (state_q == IDLE) && reset_i;
  assign valid_o = valid_q;
  assign x_o     = x_q;

endmodule

// File: tb/tb_sigmoid_inv.sv
// Directed testbench for sigmoid_inv. Tables are placed into the DUT's table
// RAM and mirrored in a local copy. Expected results come from a linear-scan
// reference over that local copy.
module tb_sigmoid_inv;

  logic       clk_i;
  logic       reset_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] y_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] x_o;

  int checks;
  int failures;

  logic [7:0] tbl [256];

  sigmoid_inv #(
    .width_p    (8),
    .filename_p ("sigmoid.hex")
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .y_i     (y_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .x_o     (x_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Table kinds: 0 = ramp T[a]=a, 1 = constant 8'h10, 2 = stepped sigmoid-like curve.
  task automatic load_table(input int kind);
    for (int a = 0; a < 256; a++) begin
      int v;
      case (kind)
        0:       v = a;
        1:       v = 16;
        default: begin
          v = (((a - 128) >>> 2) * 8) + 128;
          if (v < 0) v = 0;
          if (v > 255) v = 255;
        end
      endcase
      tbl[a] = 8'(v);
      dut.u_ram.mem_q[a] = 8'(v);
    end
  endtask

  // Linear-scan reference: first address whose entry reaches y, else the top address.
  function automatic logic [7:0] ref_x(input logic [7:0] y);
    for (int a = 0; a < 256; a++) begin
      if (tbl[a] >= y) return 8'(a) ^ 8'h80;
    end
    return 8'h7F;
  endfunction

  // Issue one request from a negedge and wait for its result.
  // lat is the count of negedges after the handshake edge up to the first one
  // where valid_o is seen; it is -1 on timeout. The result is then consumed.
  task automatic do_request(input logic [7:0] y, output logic [7:0] x, output int lat);
    int n;
    n = 0;
    while (!ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    valid_i = 1'b1;
    y_i     = y;
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    x = x_o;
    if (!valid_o) lat = -1;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_low: got %b want 0", ready_o);
    end
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b want 0", valid_o);
    end
    checks++;
    if (x_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_x: got %h want 00", x_o);
    end
    reset_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after: got %b want 1", ready_o);
    end
  endtask

  task automatic test_ramp();
    logic [7:0] ys  [3];
    logic [7:0] exp [3];
    logic [7:0] x;
    int lat;
    ys  = '{8'h00, 8'h80, 8'hFF};
    exp = '{8'h80, 8'h00, 8'h7F};
    load_table(0);
    for (int i = 0; i < 3; i++) begin
      do_request(ys[i], x, lat);
      $display("ramp y=%h x=%h lat=%0d", ys[i], x, lat);
      checks++;
      if (x !== exp[i]) begin
        failures++;
        $display("FAIL ramp_x y=%h: got %h want %h", ys[i], x, exp[i]);
      end
      checks++;
      if (lat != 9) begin
        failures++;
        $display("FAIL ramp_latency y=%h: got %0d want 9", ys[i], lat);
      end
    end
  endtask

  task automatic test_constant();
    logic [7:0] ys  [3];
    logic [7:0] exp [3];
    logic [7:0] x;
    int lat;
    ys  = '{8'h05, 8'h10, 8'h20};
    exp = '{8'h80, 8'h80, 8'h7F};
    load_table(1);
    for (int i = 0; i < 3; i++) begin
      do_request(ys[i], x, lat);
      $display("const y=%h x=%h lat=%0d", ys[i], x, lat);
      checks++;
      if (x !== exp[i]) begin
        failures++;
        $display("FAIL const_x y=%h: got %h want %h", ys[i], x, exp[i]);
      end
    end
  endtask

  task automatic test_sigmoid_sweep();
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] exp;
    int lat;
    load_table(2);
    for (int a = 0; a < 256; a++) begin
      y   = tbl[a];
      exp = ref_x(y);
      do_request(y, x, lat);
      $display("sweep x_in=%h y=%h x=%h want=%h", 8'(a) ^ 8'h80, y, x, exp);
      checks++;
      if (x !== exp || lat != 9) begin
        failures++;
        $display("FAIL sweep a=%0d y=%h: got x=%h lat=%0d want x=%h lat=9", a, y, x, lat, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    load_table(0);
    valid_i = 1'b1;
    y_i     = 8'h40;
    @(negedge clk_i);
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    for (int c = 0; c < 20; c++) begin
      valid_i = c[0];
      y_i     = 8'(c * 13);
      checks++;
      if (valid_o !== 1'b1 || x_o !== 8'hC0 || ready_o !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold c=%0d: got valid=%b x=%h ready=%b want 1 c0 0",
                 c, valid_o, x_o, ready_o);
      end
      @(negedge clk_i);
    end
    // Release with valid_i also high; only ready_i matters in DONE.
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    ready_i = 1'b0;
    $display("backpressure release ready=%b valid=%b x=%h", ready_o, valid_o, x_o);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: got ready=%b valid=%b want 1 0", ready_o, valid_o);
    end
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_no_accept: got ready=%b want 1", ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int n;
    logic [7:0] x;
    int lat;
    load_table(0);
    // Reset during the 4th SEARCH cycle.
    valid_i = 1'b1;
    y_i     = 8'h80;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    $display("reset_search valid=%b x=%h", valid_o, x_o);
    checks++;
    if (valid_o !== 1'b0 || x_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_search: got valid=%b x=%h want 0 00", valid_o, x_o);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
    checks++;
    if (seen != 0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_search_discard: got valid_cycles=%0d ready=%b want 0 1", seen, ready_o);
    end
    // Reset while holding a result in DONE.
    valid_i = 1'b1;
    y_i     = 8'h40;
    @(negedge clk_i);
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (valid_o !== 1'b1 || x_o !== 8'hC0) begin
      failures++;
      $display("FAIL reset_done_pre: got valid=%b x=%h want 1 c0", valid_o, x_o);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    $display("reset_done valid=%b x=%h", valid_o, x_o);
    checks++;
    if (valid_o !== 1'b0 || x_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_done: got valid=%b x=%h want 0 00", valid_o, x_o);
    end
    // A fresh request after reset.
    do_request(8'h80, x, lat);
    $display("post_reset y=80 x=%h lat=%0d", x, lat);
    checks++;
    if (x !== 8'h00 || lat != 9) begin
      failures++;
      $display("FAIL post_reset: got x=%h lat=%0d want 00 9", x, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ys [5];
    int idx;
    int last;
    int cyc;
    logic [7:0] exp;
    ys = '{8'h00, 8'h80, 8'hFF, 8'h33, 8'h01};
    load_table(0);
    ready_i = 1'b1;
    valid_i = 1'b1;
    y_i     = ys[0];
    idx  = 0;
    last = 0;
    cyc  = 0;
    while (idx < 5 && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
      if (valid_o) begin
        exp = ref_x(ys[idx]);
        $display("b2b y=%h x=%h cycle=%0d", ys[idx], x_o, cyc);
        checks++;
        if (x_o !== exp) begin
          failures++;
          $display("FAIL b2b_x y=%h: got %h want %h", ys[idx], x_o, exp);
        end
        if (idx > 0) begin
          checks++;
          if (cyc - last != 10) begin
            failures++;
            $display("FAIL b2b_interval idx=%0d: got %0d want 10", idx, cyc - last);
          end
        end
        last = cyc;
        idx++;
        if (idx < 5) y_i = ys[idx];
      end
    end
    valid_i = 1'b0;
    checks++;
    if (idx != 5) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 5", idx);
    end
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_i  = 1'b0;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    y_i      = 8'h00;
    @(negedge clk_i);
    test_reset();
    test_ramp();
    test_constant();
    test_sigmoid_sweep();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
